gshare_btb_predictor: RTL and testbench

- Parametrised gshare branch predictor with tagged BTB for the 5-stage RISC-V pipeline.
- Sits in IF: given the fetch PC it produces the predicted next PC. Resolution feedback from EX trains the BTB, PHT and GHR.
- Differs from the fixed 5-bit-history predictor in three ways: configurable depth, history and counter widths; tag check; speculative GHR with checkpoint restore on mispredict.

---
 rtl/gshare_btb_predictor_pkg.sv | 21 ++
 rtl/gshare_btb_predictor_sat_counter_bank.sv | 32 +++
 rtl/gshare_btb_predictor.sv | 103 ++++++++++
 tb/tb_gshare_btb_predictor.sv | 132 +++++++++++++
 4 files changed

// File: rtl/gshare_btb_predictor_pkg.sv
// gshare_btb_predictor_pkg: shared geometry defaults, BTB entry layout and counter helpers
package gshare_btb_predictor_pkg;
  localparam int DEF_PC_WIDTH     = 32;
  localparam int DEF_BTB_IDX_BITS = 5;
  localparam int DEF_PHT_IDX_BITS = 6;
  localparam int DEF_GHR_BITS     = 5;
  localparam int DEF_CTR_BITS     = 2;
  localparam int DEF_TAG_BITS     = DEF_PC_WIDTH - DEF_BTB_IDX_BITS - 2;
  typedef struct packed {
    logic                      valid;
    logic [DEF_TAG_BITS-1:0]   tag;
    logic [DEF_PC_WIDTH-1:0]   target;
    logic                      is_jump;
  } btb_entry_t;
  function automatic int tag_bits(input int pc_w, input int idx_bits);
    return pc_w - idx_bits - 2;
  endfunction
  function automatic logic [31:0] ctr_reset(input int ctr_bits);
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction
endpackage

// File: rtl/gshare_btb_predictor_sat_counter_bank.sv
// gshare_sat_counter_bank: PHT array of saturating counters with async reset to weakly not-taken
module gshare_sat_counter_bank
  import gshare_btb_predictor_pkg::*;
#(
  parameter int IDX_BITS = DEF_PHT_IDX_BITS,
  parameter int CTR_BITS = DEF_CTR_BITS
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_msb_o,
  input  logic                wr_en_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic                wr_inc_i
);
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  logic [CTR_BITS-1:0] ctr_q [2**IDX_BITS];
  logic [CTR_BITS-1:0] cur, ctr_d;
  assign cur      = ctr_q[wr_idx_i];
  assign rd_msb_o = ctr_q[rd_idx_i][CTR_BITS-1];
  // saturating step of the counter being trained
  always_comb begin
    ctr_d = wr_inc_i ? ((cur == CTR_MAX) ? cur : cur + CTR_BITS'(1))
                     : ((cur == '0) ? cur : cur - CTR_BITS'(1));
  end
  // counter storage; reads see pre-edge contents
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) for (int i = 0; i < 2**IDX_BITS; i++) ctr_q[i] <= CTR_RST;
    else if (wr_en_i) ctr_q[wr_idx_i] <= ctr_d;
  end
endmodule

// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor: gshare + tagged BTB next-PC predictor; GSHARE_PRED_STATS_EN adds event counters
module gshare_btb_predictor
  import gshare_btb_predictor_pkg::*;
#(
  parameter int PC_WIDTH     = DEF_PC_WIDTH,
  parameter int BTB_IDX_BITS = DEF_BTB_IDX_BITS,
  parameter int PHT_IDX_BITS = DEF_PHT_IDX_BITS,
  parameter int GHR_BITS     = DEF_GHR_BITS,
  parameter int CTR_BITS     = DEF_CTR_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lookup_valid,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic [PC_WIDTH-1:0] pred_next_pc,
  output logic                pred_taken,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_is_branch,
  input  logic                upd_is_jump,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                upd_mispredict
`ifdef GSHARE_PRED_STATS_EN
  ,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispredicts
`endif
);
  localparam int TAG_BITS = tag_bits(PC_WIDTH, BTB_IDX_BITS);
  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [PC_WIDTH-1:0] target;
    logic                is_jump;
  } entry_t;
  entry_t                  btb_q [2**BTB_IDX_BITS];
  entry_t                  rd_e;
  logic [GHR_BITS-1:0]     ghr_q, ghr_d;
  logic [BTB_IDX_BITS-1:0] rd_idx, wr_idx;
  logic                    hit, ctr_msb, spec_shift, restore;
  logic                    unused_ok;
  assign unused_ok  = ^upd_pc[1:0];
  assign rd_idx     = lookup_pc[BTB_IDX_BITS+1:2];
  assign wr_idx     = upd_pc[BTB_IDX_BITS+1:2];
  assign rd_e       = btb_q[rd_idx];
  assign hit        = rd_e.valid && (rd_e.tag == lookup_pc[PC_WIDTH-1:BTB_IDX_BITS+2]);
  assign pred_ghr   = ghr_q;
  assign spec_shift = lookup_valid && hit && !rd_e.is_jump;
  assign restore    = upd_valid && upd_mispredict;
  // prediction and next-history selection; a mispredict restore beats speculation
  always_comb begin
    pred_taken   = hit && (rd_e.is_jump || ctr_msb);
    pred_next_pc = pred_taken ? rd_e.target : lookup_pc + PC_WIDTH'(4);
    ghr_d        = restore ? (upd_is_branch ? {upd_ghr[GHR_BITS-2:0], upd_taken} : upd_ghr)
                 : spec_shift ? {ghr_q[GHR_BITS-2:0], pred_taken} : ghr_q;
  end
  gshare_sat_counter_bank #(
    .IDX_BITS (PHT_IDX_BITS),
    .CTR_BITS (CTR_BITS)
  ) u_pht (
    .clk      (clk),
    .rst_i    (reset),
    .rd_idx_i (lookup_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr_q)),
    .rd_msb_o (ctr_msb),
    .wr_en_i  (upd_valid && upd_is_branch),
    .wr_idx_i (upd_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(upd_ghr)),
    .wr_inc_i (upd_taken)
  );
  // BTB allocation on taken outcomes only; the new entry evicts whatever shared the slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) for (int i = 0; i < 2**BTB_IDX_BITS; i++) btb_q[i] <= '0;
    else if (upd_valid && upd_taken)
      btb_q[wr_idx] <= entry_t'{1'b1, upd_pc[PC_WIDTH-1:BTB_IDX_BITS+2], upd_target, upd_is_jump};
  end
  // global history register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ghr_q <= '0;
    else ghr_q <= ghr_d;
  end
  assert property (@(posedge clk) disable iff (reset) upd_valid |-> !(upd_is_branch && upd_is_jump));
`ifdef GSHARE_PRED_STATS_EN
  logic [31:0] stat_lookups_q, stat_updates_q, stat_mispredicts_q;
  assign stat_lookups     = stat_lookups_q;
  assign stat_updates     = stat_updates_q;
  assign stat_mispredicts = stat_mispredicts_q;
  // free-running wrapping event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lookups_q     <= '0;
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_lookups_q     <= stat_lookups_q + 32'(lookup_valid);
      stat_updates_q     <= stat_updates_q + 32'(upd_valid);
      stat_mispredicts_q <= stat_mispredicts_q + 32'(restore);
    end
  end
`endif
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// tb_gshare_btb_predictor: directed self-checking bench for the gshare/BTB predictor
module tb_gshare_btb_predictor;
  logic        clk = 1'b0, reset = 1'b1;
  logic        lookup_valid, upd_valid, upd_is_branch, upd_is_jump, upd_taken, upd_mispredict;
  logic [31:0] lookup_pc, upd_pc, upd_target, pred_next_pc;
  logic [4:0]  upd_ghr, pred_ghr;
  logic        pred_taken;
  int          n_pass = 0, n_total = 0;
`ifdef GSHARE_PRED_STATS_EN
  logic [31:0] stat_lookups, stat_updates, stat_mispredicts;
`endif
  gshare_btb_predictor dut (
    .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_next_pc(pred_next_pc), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict)
`ifdef GSHARE_PRED_STATS_EN
    , .stat_lookups(stat_lookups), .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
`endif
  );
  always #5 clk = ~clk;

  task automatic idle_upd();
    upd_valid = 0; upd_pc = 0; upd_ghr = 0; upd_is_branch = 0; upd_is_jump = 0;
    upd_taken = 0; upd_target = 0; upd_mispredict = 0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic [4:0] ghr, input logic br,
                           input logic tk, input logic [31:0] tgt, input logic mp);
    upd_valid = 1; upd_pc = pc; upd_ghr = ghr; upd_is_branch = br; upd_is_jump = !br;
    upd_taken = tk; upd_target = tgt; upd_mispredict = mp;
  endtask

  task automatic test_reset();
    lookup_valid = 0; lookup_pc = 32'h40; idle_upd();
    #1;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL rst_taken got %0b want 0", pred_taken); else n_pass++;
    n_total++; if (pred_next_pc !== 32'h44) $display("FAIL rst_next got %h want 00000044", pred_next_pc); else n_pass++;
    n_total++; if (pred_ghr !== 5'd0) $display("FAIL rst_ghr got %b want 00000", pred_ghr); else n_pass++;
    @(negedge clk); reset = 0; #1;
    n_total++; if (pred_next_pc !== 32'h44) $display("FAIL post_rst_next got %h want 00000044", pred_next_pc); else n_pass++;
  endtask

  task automatic test_jump();
    @(negedge clk); lookup_pc = 32'h80; drive_upd(32'h80, 5'd0, 0, 1, 32'h200, 1); #1;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL jump_pre_write got %0b want 0", pred_taken); else n_pass++;
    @(negedge clk); idle_upd(); lookup_valid = 1; #1;
    n_total++; if (pred_taken !== 1'b1) $display("FAIL jump_taken got %0b want 1", pred_taken); else n_pass++;
    n_total++; if (pred_next_pc !== 32'h200) $display("FAIL jump_next got %h want 00000200", pred_next_pc); else n_pass++;
    @(negedge clk); lookup_valid = 0; #1;
    n_total++; if (pred_ghr !== 5'd0) $display("FAIL jump_no_shift got %b want 00000", pred_ghr); else n_pass++;
  endtask

  task automatic test_branch();
    @(negedge clk); drive_upd(32'h100, 5'd0, 1, 1, 32'hF0, 0);
    @(negedge clk); drive_upd(32'h100, 5'd0, 1, 1, 32'hF0, 0);
    @(negedge clk); idle_upd(); lookup_pc = 32'h100; lookup_valid = 1; #1;
    n_total++; if (pred_taken !== 1'b1) $display("FAIL br_taken got %0b want 1", pred_taken); else n_pass++;
    n_total++; if (pred_next_pc !== 32'hF0) $display("FAIL br_next got %h want 000000f0", pred_next_pc); else n_pass++;
    n_total++; if (pred_ghr !== 5'd0) $display("FAIL br_ghr_before got %b want 00000", pred_ghr); else n_pass++;
    @(negedge clk); lookup_valid = 0; #1;
    n_total++; if (pred_ghr !== 5'b00001) $display("FAIL br_ghr_shift got %b want 00001", pred_ghr); else n_pass++;
  endtask

  task automatic test_alias();
    @(negedge clk); lookup_pc = 32'h180; lookup_valid = 1; #1;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL alias_taken got %0b want 0", pred_taken); else n_pass++;
    n_total++; if (pred_next_pc !== 32'h184) $display("FAIL alias_next got %h want 00000184", pred_next_pc); else n_pass++;
    @(negedge clk); lookup_valid = 0; #1;
    n_total++; if (pred_ghr !== 5'b00001) $display("FAIL alias_ghr got %b want 00001", pred_ghr); else n_pass++;
  endtask

  task automatic test_restore();
    @(negedge clk); lookup_pc = 32'h100; lookup_valid = 1; drive_upd(32'h300, 5'b00101, 1, 0, 32'h0, 1); #1;
    n_total++; if (pred_next_pc !== 32'h104) $display("FAIL restore_pred got %h want 00000104", pred_next_pc); else n_pass++;
    @(negedge clk); lookup_valid = 0; idle_upd(); #1;
    n_total++; if (pred_ghr !== 5'b01010) $display("FAIL restore_ghr got %b want 01010", pred_ghr); else n_pass++;
  endtask

  task automatic test_saturation();
    @(negedge clk); drive_upd(32'h3C, 5'd0, 1, 1, 32'h500, 0);
    @(negedge clk); idle_upd(); lookup_pc = 32'h3C; #1;
    n_total++; if (pred_next_pc !== 32'h40) $display("FAIL sat_start got %h want 00000040", pred_next_pc); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive_upd(32'h300, 5'b00101, 1, 0, 32'h0, 0);
      @(negedge clk); idle_upd(); #1;
      n_total++; if (pred_taken !== 1'b0) $display("FAIL sat_floor_%0d got %0b want 0", i, pred_taken); else n_pass++;
    end
    @(negedge clk); drive_upd(32'h3C, 5'b01010, 1, 1, 32'h500, 0);
    @(negedge clk); idle_upd(); #1;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL sat_up1 got %0b want 0", pred_taken); else n_pass++;
    @(negedge clk); drive_upd(32'h3C, 5'b01010, 1, 1, 32'h500, 0);
    @(negedge clk); idle_upd(); #1;
    n_total++; if (pred_next_pc !== 32'h500) $display("FAIL sat_up2 got %h want 00000500", pred_next_pc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); lookup_pc = 32'h3C; drive_upd(32'h3C, 5'b11111, 0, 1, 32'h600, 0); #1;
    n_total++; if (pred_next_pc !== 32'h500) $display("FAIL rdw_old got %h want 00000500", pred_next_pc); else n_pass++;
    @(negedge clk); drive_upd(32'h3C, 5'b10011, 0, 1, 32'h600, 1); #1;
    n_total++; if (pred_next_pc !== 32'h600) $display("FAIL rdw_new got %h want 00000600", pred_next_pc); else n_pass++;
    n_total++; if (pred_ghr !== 5'b01010) $display("FAIL jump_nomp_ghr got %b want 01010", pred_ghr); else n_pass++;
    @(negedge clk); idle_upd(); #1;
    n_total++; if (pred_ghr !== 5'b10011) $display("FAIL jump_restore_ghr got %b want 10011", pred_ghr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); lookup_pc = 32'h3C; drive_upd(32'h80, 5'b11111, 0, 1, 32'h700, 1);
    #2 reset = 1; #1;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL midrst_taken got %0b want 0", pred_taken); else n_pass++;
    n_total++; if (pred_next_pc !== 32'h40) $display("FAIL midrst_next got %h want 00000040", pred_next_pc); else n_pass++;
    n_total++; if (pred_ghr !== 5'd0) $display("FAIL midrst_ghr got %b want 00000", pred_ghr); else n_pass++;
    @(negedge clk); reset = 0; idle_upd(); lookup_pc = 32'h80; #1;
    n_total++; if (pred_next_pc !== 32'h84) $display("FAIL midrst_80 got %h want 00000084", pred_next_pc); else n_pass++;
    lookup_pc = 32'h100; #1;
    n_total++; if (pred_next_pc !== 32'h104) $display("FAIL midrst_100 got %h want 00000104", pred_next_pc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_jump();
    test_branch();
    test_alias();
    test_restore();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
